sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
Two-port arbiter and sequencer for the shared 16-bit asynchronous SRAM.
- Port 0 is the CPU memory path; port 1 is the debug/program loader.
- Grants one requester at a time and latches its address, write data and direction.
- Drives the active-low SRAM strobes through a fixed setup/access/done sequence, then returns read data with a one-cycle acknowledge.

Parameters:
WAIT_CYCLES, 2, number of ACCESS-state cycles per transfer; legal range 1..15.
ADDR_W, 20, SRAM address width.
DATA_W, 16, SRAM data width.

Ports:
Clk  in  1  system clock; all state changes on the rising edge
Reset  in  1  synchronous, active-high reset
req0  in  1  port 0 request; held high until ack0
we0  in  1  port 0 direction: 1 = write, 0 = read
addr0  in  ADDR_W  port 0 address
wdata0  in  DATA_W  port 0 write data
ack0  out  1  one-cycle transfer-complete pulse for port 0
req1, we1, addr1, wdata1, ack1  same as port 0, for port 1
rdata  out  DATA_W  read data of the last completed read; shared by both ports
busy  out  1  high in every state except IDLE
grant  out  2  one-hot owner of the current transfer; 00 in IDLE
Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE  out  1 each  SRAM strobes, active low
ADDR  out  ADDR_W  SRAM address
Mem_Dout  out  DATA_W  write data to the external tri-state buffer
Mem_Dout_En  out  1  tri-state enable for Mem_Dout
Mem_Din  in  DATA_W  SRAM read data

Behaviour:
- States: IDLE, SETUP, ACCESS, DONE. All outputs are registered.
- Reset values: state IDLE; all Mem_* strobes 1; ADDR 0; Mem_Dout 0; Mem_Dout_En 0; rdata 0; ack0/ack1 0; grant 00; busy 0; round-robin pointer last = 1, so port 0 wins first.
- IDLE:
  - No request: stay in IDLE.
  - Otherwise select a winner: if only one port requests, it wins; if both request, the port != last wins.
  - Latch the winner's addr, we and wdata into internal registers.
  - Set grant; set last = winner; go to SETUP.
- SETUP, one cycle:
  - ADDR = latched address; CE, UB, LB = 0.
  - Read: OE = 0.
  - Write: Mem_Dout_En = 1 and Mem_Dout = latched data; WE stays 1 to give address setup time.
- ACCESS, WAIT_CYCLES cycles, timed by a wait counter:
  - Read: OE = 0; Mem_Din is captured into rdata on the final ACCESS edge.
  - Write: WE = 0.
- DONE, one cycle:
  - WE and OE = 1; CE, UB, LB and ADDR held; Mem_Dout_En held for write hold time.
  - Pulse ack of the granted port. Next state IDLE, where strobes, grant and Mem_Dout_En are released.
- Timing, WAIT_CYCLES = 2, request first seen in IDLE at cycle 0: SETUP at 1, ACCESS at 2–3, ack high at cycle 4, IDLE at cycle 5. Minimum transfer period is WAIT_CYCLES + 3 cycles.
- Handshake rules:
  - A requester drops req in the cycle after ack.
  - If req is still high in the IDLE cycle that follows ack, it is treated as a new request and re-arbitrated, so no starvation under round-robin.
  - Changes to addr, we or wdata after grant are ignored.
  - A req dropped mid-transfer does not abort the transfer; ack is still issued.
- Read data: rdata holds its value until the next read completes; writes do not modify rdata.
- Simultaneous requests: strict alternation under round-robin.
- Reset mid-transfer: on the next edge state is IDLE, strobes are 1, Mem_Dout_En is 0, no ack is issued and last = 1. The interrupted write is undefined at the SRAM.
- ack0 and ack1 are never high in the same cycle. ack is never high outside DONE.

Optional Feature:
ARB_FIXED_PRIO_EN
- Defined: port 0 always wins simultaneous requests and the last pointer is ignored. Port 1 is served only when req0 is low in an IDLE cycle.
- Undefined: round-robin arbitration as specified in Behaviour.

Test Plan:
- Port 0 read of 0x00010 with SRAM model word 0xBEEF, WAIT_CYCLES = 2 → OE low cycles 1–3, ack0 high at cycle 4 only, rdata = 0xBEEF, grant = 01 during cycles 1–4.
- Port 1 write of 0x1234 to 0x00020 → WE low exactly 2 cycles, Mem_Dout_En high cycles 1–4, model reads back 0x1234, rdata unchanged.
- req0 and req1 held high continuously, both doing reads → grants alternate 0,1,0,1; acks at cycles 4, 9, 14, 19. With ARB_FIXED_PRIO_EN defined: only ack0, at cycles 4, 9, 14, 19.
- addr0 changed from 0x00010 to 0x00099 during SETUP → SRAM model sees only 0x00010.
- Reset asserted in the first ACCESS cycle of a write → next cycle all strobes 1, busy 0, no ack; a following port 0 read completes normally.
- WAIT_CYCLES = 1 → back-to-back port 0 reads have ack spacing of 4 cycles.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and strobe sequencer for a shared asynchronous SRAM.
// Define ARB_FIXED_PRIO_EN to give port 0 fixed priority over port 1.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2,
    parameter int unsigned ADDR_W      = 20,
    parameter int unsigned DATA_W      = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              ack0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              ack1,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic [1:0]        grant,
    output logic              Mem_CE,
    output logic              Mem_UB,
    output logic              Mem_LB,
    output logic              Mem_OE,
    output logic              Mem_WE,
    output logic [ADDR_W-1:0] ADDR,
    output logic [DATA_W-1:0] Mem_Dout,
    output logic              Mem_Dout_En,
    input  logic [DATA_W-1:0] Mem_Din
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

    state_t            state, state_d;
    logic [3:0]        cnt, cnt_d;
    logic              last, last_d;
    logic              we_q, we_d;
    logic              pick1;
    logic              ack0_d, ack1_d, busy_d, ce_d, oe_d, wen_d, den_d;
    logic [1:0]        grant_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] dout_d, rdata_d;

    // The ADDR and Mem_Dout registers double as the latched request fields.
`ifdef ARB_FIXED_PRIO_EN
    assign pick1 = ~req0;
`else
    assign pick1 = (req0 & req1) ? ~last : req1;
`endif

    assign Mem_UB = Mem_CE;
    assign Mem_LB = Mem_CE;

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        last_d  = last;
        we_d    = we_q;
        addr_d  = ADDR;
        dout_d  = Mem_Dout;
        rdata_d = rdata;
        grant_d = grant;
        ce_d    = Mem_CE;
        oe_d    = Mem_OE;
        wen_d   = Mem_WE;
        den_d   = Mem_Dout_En;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        unique case (state)
            IDLE: begin
                if (req0 | req1) begin
                    state_d = SETUP;
                    last_d  = pick1;
                    grant_d = pick1 ? 2'b10 : 2'b01;
                    we_d    = pick1 ? we1 : we0;
                    addr_d  = pick1 ? addr1 : addr0;
                    dout_d  = pick1 ? wdata1 : wdata0;
                    ce_d    = 1'b0;
                    oe_d    = we_d;
                    den_d   = we_d;
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = WAIT_LAST;
                wen_d   = ~we_q;
            end
            ACCESS: begin
                if (cnt == 4'd0) begin
                    state_d = DONE;
                    oe_d    = 1'b1;
                    wen_d   = 1'b1;
                    ack0_d  = grant[0];
                    ack1_d  = grant[1];
                    if (!we_q) begin
                        rdata_d = Mem_Din;
                    end
                end else begin
                    cnt_d = cnt - 4'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
                ce_d    = 1'b1;
                den_d   = 1'b0;
                grant_d = 2'b00;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last        <= 1'b1;
            we_q        <= 1'b0;
            ADDR        <= '0;
            Mem_Dout    <= '0;
            rdata       <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            Mem_CE      <= 1'b1;
            Mem_OE      <= 1'b1;
            Mem_WE      <= 1'b1;
            Mem_Dout_En <= 1'b0;
            ack0        <= 1'b0;
            ack1        <= 1'b0;
        end else begin
            state       <= state_d;
            cnt         <= cnt_d;
            last        <= last_d;
            we_q        <= we_d;
            ADDR        <= addr_d;
            Mem_Dout    <= dout_d;
            rdata       <= rdata_d;
            grant       <= grant_d;
            busy        <= busy_d;
            Mem_CE      <= ce_d;
            Mem_OE      <= oe_d;
            Mem_WE      <= wen_d;
            Mem_Dout_En <= den_d;
            ack0        <= ack0_d;
            ack1        <= ack1_d;
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: transfer-level reference model plus directed and random stimulus.
module tb_sram_arbiter;

    localparam int W = 2;

    logic        Clk, Reset;
    logic        req0, we0, req1, we1, ack0, ack1, busy;
    logic [19:0] addr0, addr1, ADDR;
    logic [15:0] wdata0, wdata1, rdata, Mem_Dout, Mem_Din;
    logic [1:0]  grant;
    logic        Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE, Mem_Dout_En;

    logic        r2_req, ack0_2, ack1_2, busy_2, ce2, ub2, lb2, oe2, we2, den2;
    logic [19:0] addr_2;
    logic [15:0] rdata_2, dout_2, din_2;
    logic [1:0]  grant_2;

    logic [15:0] sram_mem [256];
    logic [15:0] mem_ref  [256];

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    sram_arbiter #(.WAIT_CYCLES(W), .ADDR_W(20), .DATA_W(16)) u_dut (
        .Clk(Clk), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1),
        .rdata(rdata), .busy(busy), .grant(grant),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .ADDR(ADDR), .Mem_Dout(Mem_Dout), .Mem_Dout_En(Mem_Dout_En), .Mem_Din(Mem_Din)
    );

    sram_arbiter #(.WAIT_CYCLES(1), .ADDR_W(20), .DATA_W(16)) u_dut_w1 (
        .Clk(Clk), .Reset(Reset),
        .req0(r2_req), .we0(1'b0), .addr0(20'h00010), .wdata0(16'h0000), .ack0(ack0_2),
        .req1(1'b0), .we1(1'b0), .addr1(20'h00000), .wdata1(16'h0000), .ack1(ack1_2),
        .rdata(rdata_2), .busy(busy_2), .grant(grant_2),
        .Mem_CE(ce2), .Mem_UB(ub2), .Mem_LB(lb2), .Mem_OE(oe2), .Mem_WE(we2),
        .ADDR(addr_2), .Mem_Dout(dout_2), .Mem_Dout_En(den2), .Mem_Din(din_2)
    );

    initial Clk = 0;
    always #5 Clk = ~Clk;

    // Asynchronous SRAM: reads while CE and OE are low, writes while CE and WE are low.
    assign Mem_Din = (!Mem_CE && !Mem_OE) ? sram_mem[ADDR[7:0]] : 16'h0000;
    assign din_2   = (!ce2 && !oe2) ? sram_mem[addr_2[7:0]] : 16'h0000;

    always @(posedge Clk) begin
        if (!Mem_CE && !Mem_WE && Mem_Dout_En) sram_mem[ADDR[7:0]] = Mem_Dout;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: k is the offset of the current cycle within a transfer
    // (0 = idle, 1 = setup, 2..W+1 = access, W+2 = done).
    int          cur_k;
    int          m_port, m_last;
    logic        m_we;
    logic [19:0] m_addr;
    logic [15:0] m_data, m_rdata;

    always @(posedge Clk) begin
        if (Reset) begin
            cur_k = 0; m_last = 1; m_rdata = 16'h0000; m_port = 0; m_we = 0;
        end else if (cur_k == 0) begin
            if (req0 || req1) begin
`ifdef ARB_FIXED_PRIO_EN
                m_port = req0 ? 0 : 1;
`else
                m_port = (req0 && req1) ? 1 - m_last : (req0 ? 0 : 1);
`endif
                m_last = m_port;
                m_we   = m_port == 1 ? we1 : we0;
                m_addr = m_port == 1 ? addr1 : addr0;
                m_data = m_port == 1 ? wdata1 : wdata0;
                cur_k  = 1;
            end
        end else if (cur_k == W + 2) begin
            cur_k = 0;
        end else begin
            if (cur_k == W + 1) begin
                if (m_we) mem_ref[m_addr[7:0]] = m_data;
                else      m_rdata = mem_ref[m_addr[7:0]];
            end
            cur_k++;
        end
    end

    always @(negedge Clk) begin : cmp
        bit act, rd, wr;
        if (chk_en) begin
            act = cur_k != 0;
            rd  = act && !m_we;
            wr  = act && m_we;
            chk("busy", 32'(busy), 32'(act));
            chk("grant", 32'(grant), act ? (m_port == 1 ? 32'd2 : 32'd1) : 32'd0);
            chk("ce_ub_lb", 32'({Mem_CE, Mem_UB, Mem_LB}), act ? 32'd0 : 32'd7);
            chk("oe", 32'(Mem_OE), 32'(!(rd && cur_k <= W + 1)));
            chk("we", 32'(Mem_WE), 32'(!(wr && cur_k >= 2 && cur_k <= W + 1)));
            chk("dout_en", 32'(Mem_Dout_En), 32'(wr));
            chk("ack0", 32'(ack0), 32'(act && cur_k == W + 2 && m_port == 0));
            chk("ack1", 32'(ack1), 32'(act && cur_k == W + 2 && m_port == 1));
            chk("rdata", 32'(rdata), 32'(m_rdata));
            if (act) chk("addr", 32'(ADDR), 32'(m_addr));
            if (wr)  chk("dout", 32'(Mem_Dout), 32'(m_data));
        end
    end

    task automatic set_port(input int p, input logic r, input logic w,
                            input logic [19:0] a, input logic [15:0] d);
        if (p == 0) begin req0 = r; we0 = w; addr0 = a; wdata0 = d; end
        else        begin req1 = r; we1 = w; addr1 = a; wdata1 = d; end
    endtask

    // Runs one transfer from the cycle the request is raised (cycle 0) and returns
    // per-cycle masks for cycles 0..7; req drops in the cycle after ack.
    task automatic xfer(input int p, input logic w, input logic [19:0] a, input logic [15:0] d,
                        input int chg_at, input logic [19:0] a2,
                        output logic [7:0] oe_m, output logic [7:0] we_m, output logic [7:0] den_m,
                        output logic [7:0] ack_m, output logic [7:0] g_m, output logic [7:0] a_m);
        logic r;
        bit   got;
        r = 1; got = 0;
        set_port(p, r, w, a, d);
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            oe_m[c]  = !Mem_OE;
            we_m[c]  = !Mem_WE;
            den_m[c] = Mem_Dout_En;
            ack_m[c] = (p == 0) ? ack0 : ack1;
            g_m[c]   = grant == ((p == 0) ? 2'b01 : 2'b10);
            a_m[c]   = !Mem_CE && ADDR == a;
            if (ack_m[c]) got = 1;
            @(posedge Clk); #1;
            if (got) r = 0;
            if (c + 1 == chg_at) set_port(p, r, w, a2, d);
            else                 set_port(p, r, w, (c + 1 > chg_at && chg_at > 0) ? a2 : a, d);
        end
    endtask

    task automatic port_proc(input int p, input int n);
        logic        r, w;
        logic [19:0] a;
        logic [15:0] d;
        bit          got;
        r = 0; w = 0; a = '0; d = '0;
        for (int i = 0; i < n; i++) begin
            if (!r) repeat ($urandom_range(1, 4)) begin @(posedge Clk); #1; end
            w = 1'($urandom_range(0, 1));
            a = 20'(32'h40 + $urandom_range(0, 191));
            d = 16'($urandom);
            r = 1;
            set_port(p, r, w, a, d);
            got = 0;
            for (int t = 0; t < 200 && !got; t++) begin
                @(negedge Clk);
                got = (p == 0) ? ack0 : ack1;
                @(posedge Clk); #1;
                if (!got && $urandom_range(0, 3) == 0) begin
                    w = 1'($urandom_range(0, 1));
                    a = 20'(32'h40 + $urandom_range(0, 191));
                    d = 16'($urandom);
                    set_port(p, r, w, a, d);
                end
            end
            chk(p == 0 ? "ack_wait0" : "ack_wait1", 32'(got), 32'd1);
            if (!got || $urandom_range(0, 2) != 0) r = 0;
            set_port(p, r, w, a, d);
        end
        set_port(p, 1'b0, w, a, d);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [7:0]  oe_m, we_m, den_m, ack_m, g_m, a_m;
        logic [31:0] a0m, a1m;
        int          nack;

        Reset = 1; r2_req = 0;
        set_port(0, 0, 0, '0, '0);
        set_port(1, 0, 0, '0, '0);
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 16'($urandom);
        end
        sram_mem[8'h10] = 16'hBEEF;
        for (int i = 0; i < 256; i++) mem_ref[i] = sram_mem[i];

        repeat (3) @(posedge Clk);
        #1 Reset = 0; chk_en = 1;
        @(negedge Clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
        chk("rst_addr", 32'(ADDR), 32'd0);
        chk("rst_dout", 32'(Mem_Dout), 32'd0);
        chk("rst_dout_en", 32'(Mem_Dout_En), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_acks", 32'({ack0, ack1}), 32'd0);

        // Port 0 read of 0x10
        @(posedge Clk); #1;
        xfer(0, 1'b0, 20'h00010, 16'h0, 0, 20'h0, oe_m, we_m, den_m, ack_m, g_m, a_m);
        chk("rd_oe_cycles", 32'(oe_m), 32'h0E);
        chk("rd_ack_cycles", 32'(ack_m), 32'h10);
        chk("rd_grant_cycles", 32'(g_m), 32'h1E);
        chk("rd_rdata", 32'(rdata), 32'hBEEF);

        // Port 1 write of 0x1234 to 0x20
        xfer(1, 1'b1, 20'h00020, 16'h1234, 0, 20'h0, oe_m, we_m, den_m, ack_m, g_m, a_m);
        chk("wr_we_cycles", 32'(we_m), 32'h0C);
        chk("wr_den_cycles", 32'(den_m), 32'h1E);
        chk("wr_ack_cycles", 32'(ack_m), 32'h10);
        chk("wr_sram_word", 32'(sram_mem[8'h20]), 32'h1234);
        chk("wr_rdata_kept", 32'(rdata), 32'hBEEF);

        // Both ports reading continuously
        a0m = '0; a1m = '0;
        set_port(0, 1, 0, 20'h00041, 16'h0);
        set_port(1, 1, 0, 20'h00042, 16'h0);
        for (int c = 0; c < 22; c++) begin
            @(negedge Clk);
            a0m[c] = ack0;
            a1m[c] = ack1;
            @(posedge Clk); #1;
            if (c == 19) begin
                set_port(0, 0, 0, 20'h00041, 16'h0);
                set_port(1, 0, 0, 20'h00042, 16'h0);
            end
        end
`ifdef ARB_FIXED_PRIO_EN
        chk("both_ack0", a0m, 32'h00084210);
        chk("both_ack1", a1m, 32'h00000000);
`else
        chk("both_ack0", a0m, 32'h00004010);
        chk("both_ack1", a1m, 32'h00080200);
`endif

        // Address changed during SETUP is ignored
        xfer(0, 1'b0, 20'h00010, 16'h0, 1, 20'h00099, oe_m, we_m, den_m, ack_m, g_m, a_m);
        chk("chg_addr_cycles", 32'(a_m), 32'h1E);
        chk("chg_rdata", 32'(rdata), 32'hBEEF);

        // Reset during the first ACCESS cycle of a write
        set_port(0, 1, 1, 20'h00030, 16'hAAAA);
        @(posedge Clk); #1;
        @(posedge Clk); #1 Reset = 1;
        @(posedge Clk); #1 Reset = 0;
        set_port(0, 0, 1, 20'h00030, 16'hAAAA);
        @(negedge Clk);
        chk("mid_rst_strobes", 32'({Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE}), 32'h1F);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_den", 32'(Mem_Dout_En), 32'd0);
        nack = 0;
        for (int c = 0; c < 3; c++) begin
            nack += int'(ack0) + int'(ack1);
            @(negedge Clk);
        end
        chk("mid_rst_no_ack", 32'(nack), 32'd0);
        @(posedge Clk); #1;
        xfer(0, 1'b0, 20'h00010, 16'h0, 0, 20'h0, oe_m, we_m, den_m, ack_m, g_m, a_m);
        chk("post_rst_ack", 32'(ack_m), 32'h10);
        chk("post_rst_rdata", 32'(rdata), 32'hBEEF);

        // WAIT_CYCLES = 1 instance, back-to-back reads
        a0m = '0;
        r2_req = 1;
        for (int c = 0; c < 13; c++) begin
            @(negedge Clk);
            a0m[c] = ack0_2;
            @(posedge Clk); #1;
            if (c == 11) r2_req = 0;
        end
        chk("w1_ack_spacing", a0m, 32'h00000888);
        chk("w1_rdata", 32'(rdata_2), 32'hBEEF);

        // Randomized traffic on both ports
        fork
            port_proc(0, 40);
            port_proc(1, 40);
        join
        repeat (8) @(posedge Clk);
        @(negedge Clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
